dcache_mem_stage: RTL and testbench
===================================

// Module: dcache_mem_stage
// PURPOSE
//  MEM-stage data cache controller, directly downstream of the EX/MEM pipeline register.
//  Serves the load/store from EX/MEM through a direct-mapped, write-back, write-allocate cache.
//  On a miss it raises stall_o, which freezes EX/MEM and all upstream stages.
//  It runs the line writeback/refill handshake with off-chip data memory.
// PARAMETERS
//  NUM_LINES   32    cache lines; power of 2; INDEX_W = log2(NUM_LINES)
//  LINE_BITS   256   line width (8 x 32-bit words); memory beat = one full line
// PORTS
//  clk_i          in   1          clock; all state updates on posedge
//  rst_i          in   1          asynchronous, active-high reset
//  MemRead_i      in   1          load request (from EX/MEM MemRead_o)
//  MemWrite_i     in   1          store request (from EX/MEM MemWrite_o)
//  addr_i         in   32         byte address (EX/MEM ALU_result_o)
//  wdata_i        in   32         store data (EX/MEM RS2data_o)
//  rdata_o        out  32         load data to MEM/WB; valid when MemRead_i && !stall_o
//  stall_o        out  1          pipeline stall (feeds EX/MEM stall_i)
//  mem_enable_o   out  1          memory request valid
//  mem_write_o    out  1          1 = line write, 0 = line read
//  mem_addr_o     out  32         line-aligned memory address ([4:0] = 0)
//  mem_data_o     out  LINE_BITS  writeback line
//  mem_data_i     in   LINE_BITS  refill line; valid in the mem_ack_i cycle
//  mem_ack_i      in   1          one-cycle completion pulse from memory
// BEHAVIOUR
//  - Address split: word = addr_i[4:2]; index = addr_i[5+INDEX_W-1:5]; tag = addr_i[31:5+INDEX_W].
//  - req = MemRead_i | MemWrite_i. Both high is illegal and is treated as a write.
//  - hit = req & valid[index] & (tag_arr[index] == tag). Combinational.
//  - stall_o = req & ~hit, combinational. It asserts in the same cycle as a miss.
//  - stall_o stays high until the refilled line hits. No-request cycles never stall.
//  - rdata_o = selected word of the indexed line on a read hit, else 0. Load hit latency: 0 cycles.
//  - Write hit: at posedge, the addressed word is replaced by wdata_i and dirty[index] is set to 1.
//  - FSM states: IDLE, WB, RD, FILL.
//    - IDLE -> WB   on miss with victim valid & dirty.
//      Registered outputs: enable=1, write=1, addr={victim_tag,index,5'b0}, mem_data_o=victim line.
//    - IDLE -> RD   on miss with a clean or invalid victim. enable=1, write=0, addr={tag,index,5'b0}.
//    - WB   -> RD   on mem_ack_i. write<=0 and addr<=refill address in the same edge; enable stays 1.
//    - RD   -> FILL on mem_ack_i. Line <= mem_data_i, tag written, valid=1, dirty=0, enable<=0.
//    - FILL -> IDLE unconditionally. The request then hits, a store merges and sets dirty, stall drops.
//  - Miss penalty: 1 + t_wb + t_rd + 1 cycles, where t = cycles from enable to ack.
//  - mem_enable_o, mem_write_o and mem_addr_o are stable while waiting for ack.
//  - mem_ack_i is ignored in IDLE and FILL.
//  - Request inputs are held by the pipeline during a stall. The FSM uses addr_i index/tag only in IDLE.
//    WB/RD addresses are latched, so a changed input mid-miss cannot corrupt the transfer.
//  - Reset (asynchronous, at any time, including mid-transfer):
//    - FSM = IDLE; all valid and dirty bits = 0.
//    - mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0.
//    - stall_o and rdata_o follow the combinational rules (0 with no request; with a request, the
//      cleared valid bits make it a miss and stall_o = 1).
//    - Tag and data arrays need no reset.
// STRUCTURE
//  - Shared package: the state encoding (2-bit localparams IDLE/WB/RD/FILL), LINE_BITS, and the
//    field-offset constants for word/index/tag.
//  - Sub-module dcache_sram: tag + valid + dirty + data arrays.
//    - Asynchronous read and synchronous write.
//    - Writes are either a full-line fill or a word write with a 3-bit word select.
//  - The controller holds the FSM, hit logic and memory-port registers.
// TESTING
//  1. Reset, then a load from 0x0000_0040 with an ack after 10 cycles.
//     -> stall_o=1 at once; RD with addr 0x40. After ack, FILL then IDLE.
//     -> stall_o=0 and rdata_o = word 0 of mem_data_i. Total 12 stall cycles.
//  2. Store 0xDEADBEEF to 0x44 after test 1.
//     -> No stall; dirty set. A following load from 0x44 returns 0xDEADBEEF with 0 stall.
//  3. Load from 0x440 (NUM_LINES=32: same index as 0x40, different tag).
//     -> WB with mem_addr_o=0x40, mem_write_o=1, and mem_data_o word1=0xDEADBEEF.
//     -> After ack, RD with addr 0x440, write=0.
//     -> Load returns the refill word after FILL.
//  4. mem_ack_i pulsed while in IDLE with no request.
//     -> No state change, mem_enable_o stays 0, stall_o=0.
//  5. rst_i asserted during RD with mem_enable_o=1.
//     -> mem_enable_o=0 immediately. After release, a load to 0x40 misses again (valid cleared).
//  6. Back-to-back store hits to 0x48 and 0x4C, each with a different value.
//     -> Both words are updated in the line; a later writeback shows both values.

Source files
------------

// File: rtl/dcache_mem_stage_pkg.sv
// dcache_mem_stage_pkg: shared state encoding, line width and address field offsets
package dcache_mem_stage_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd1, RD = 2'd2, FILL = 2'd3} state_t;
  localparam int LINE_BITS = 256;
  localparam int WORD_LSB  = 2;
  localparam int INDEX_LSB = 5;
endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: tag/valid/dirty/data arrays, async read, sync full-line fill or word write
module dcache_sram
  import dcache_mem_stage_pkg::*;
#(
  parameter int NUM_LINES = 32,
  parameter int INDEX_W   = $clog2(NUM_LINES),
  parameter int TAG_W     = 32 - INDEX_LSB - INDEX_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [INDEX_W-1:0]   i_ridx,
  output logic                 o_valid,
  output logic                 o_dirty,
  output logic [TAG_W-1:0]     o_tag,
  output logic [LINE_BITS-1:0] o_line,
  input  logic [INDEX_W-1:0]   i_widx,
  input  logic                 i_fill,
  input  logic [TAG_W-1:0]     i_fill_tag,
  input  logic [LINE_BITS-1:0] i_fill_line,
  input  logic                 i_wr,
  input  logic [2:0]           i_wsel,
  input  logic [31:0]          i_wdata
);
  logic [NUM_LINES-1:0] r_valid, r_dirty;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [LINE_BITS-1:0] r_data [NUM_LINES];
  assign o_valid = r_valid[i_ridx];
  assign o_dirty = r_dirty[i_ridx];
  assign o_tag   = r_tag[i_ridx];
  assign o_line  = r_data[i_ridx];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill) begin
      r_valid[i_widx] <= 1'b1;
      r_dirty[i_widx] <= 1'b0;
    end else if (i_wr)
      r_dirty[i_widx] <= 1'b1;
  always_ff @(posedge clk_i)
    if (i_fill) begin
      r_tag[i_widx]  <= i_fill_tag;
      r_data[i_widx] <= i_fill_line;
    end else if (i_wr)
      r_data[i_widx][{i_wsel, 5'b0} +: 32] <= i_wdata;
endmodule

// File: rtl/dcache_mem_stage.sv
// dcache_mem_stage: direct-mapped write-back/write-allocate MEM-stage cache controller
module dcache_mem_stage
  import dcache_mem_stage_pkg::*;
#(
  parameter int NUM_LINES = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 MemRead_i,
  input  logic                 MemWrite_i,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o,
  output logic                 stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);
  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = 32 - INDEX_LSB - INDEX_W;
  state_t               r_state;
  logic [INDEX_W-1:0]   w_idx, r_idx;
  logic [TAG_W-1:0]     w_tag, r_tag, w_vtag;
  logic [2:0]           w_word;
  logic [LINE_BITS-1:0] w_line;
  logic                 w_valid, w_dirty, w_req, w_hit, w_fill, w_unused;
  assign w_word   = addr_i[INDEX_LSB-1:WORD_LSB];
  assign w_idx    = addr_i[INDEX_LSB +: INDEX_W];
  assign w_tag    = addr_i[31 -: TAG_W];
  assign w_unused = &{1'b0, addr_i[WORD_LSB-1:0]};
  assign w_req    = MemRead_i | MemWrite_i;
  // hits only count in IDLE so the FILL cycle still stalls
  assign w_hit    = w_req & (r_state == IDLE) & w_valid & (w_vtag == w_tag);
  assign stall_o  = w_req & ~w_hit;
  assign rdata_o  = (w_hit & ~MemWrite_i) ? w_line[{w_word, 5'b0} +: 32] : 32'd0;
  assign w_fill   = (r_state == RD) & mem_ack_i;
  dcache_sram #(.NUM_LINES(NUM_LINES)) u_sram (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_ridx     (w_idx),
    .o_valid    (w_valid),
    .o_dirty    (w_dirty),
    .o_tag      (w_vtag),
    .o_line     (w_line),
    .i_widx     (w_fill ? r_idx : w_idx),
    .i_fill     (w_fill),
    .i_fill_tag (r_tag),
    .i_fill_line(mem_data_i),
    .i_wr       (w_hit & MemWrite_i),
    .i_wsel     (w_word),
    .i_wdata    (wdata_i)
  );
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_tag        <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else
      case (r_state)
        IDLE: if (stall_o) begin
          r_idx        <= w_idx;
          r_tag        <= w_tag;
          mem_enable_o <= 1'b1;
          if (w_valid & w_dirty) begin
            r_state     <= WB;
            mem_write_o <= 1'b1;
            mem_addr_o  <= {w_vtag, w_idx, {INDEX_LSB{1'b0}}};
            mem_data_o  <= w_line;
          end else begin
            r_state     <= RD;
            mem_write_o <= 1'b0;
            mem_addr_o  <= {w_tag, w_idx, {INDEX_LSB{1'b0}}};
          end
        end
        WB: if (mem_ack_i) begin
          r_state     <= RD;
          mem_write_o <= 1'b0;
          mem_addr_o  <= {r_tag, r_idx, {INDEX_LSB{1'b0}}};
        end
        RD: if (mem_ack_i) begin
          r_state      <= FILL;
          mem_enable_o <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
endmodule

// File: tb/tb_dcache_mem_stage.sv
// tb_dcache_mem_stage: directed tests against a line-level cache/memory model
module tb_dcache_mem_stage;
  logic clk = 0, rst_i = 0, MemRead_i = 0, MemWrite_i = 0, mem_ack_i = 0;
  logic [31:0] addr_i = '0, wdata_i = '0, rdata_o, mem_addr_o;
  logic stall_o, mem_enable_o, mem_write_o;
  logic [255:0] mem_data_o, mem_data_i = '0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;

  dcache_mem_stage dut (
    .clk_i(clk), .rst_i(rst_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .stall_o(stall_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  // model: what each cache index holds, plus the off-chip memory image
  bit           mv[32], md_dirty[32];
  logic [21:0]  mt[32];
  logic [255:0] md[32];
  logic [255:0] mem[int];
  logic [31:0]  exp_rdata = '0, exp_wb_addr = '0, exp_rd_addr = '0;
  logic [255:0] exp_wb_data = '0;
  logic [31:0]  last_wb_addr = '0, last_rd_addr = '0, last_rdata = '0;
  logic [255:0] last_wb_data = '0;
  int t_wb = 1, t_rd = 1, last_n = 0;
  bit auto_mem = 1;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [255:0] get_line(input logic [26:0] la);
    logic [255:0] l;
    if (mem.exists(int'(la))) return mem[int'(la)];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = {la, w[2:0], 2'b00} ^ 32'hC0DE_0000;
    return l;
  endfunction

  // per-cycle compare plus memory responder
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        if (!(MemRead_i || MemWrite_i)) begin
          chk("idle_stall", stall_o, 0);
          chk("idle_rdata", rdata_o, 0);
        end else if (!stall_o)
          chk("hit_rdata", rdata_o, exp_rdata);
        if (!stall_o) chk("no_stall_enable", mem_enable_o, 0);
      end
      if (auto_mem) begin
        mem_ack_i = 0;
        if (rst_i || !mem_enable_o) cnt = 0;
        else begin
          cnt++;
          if (cnt == (mem_write_o ? t_wb : t_rd)) begin
            if (mem_write_o) begin
              chk("wb_addr", mem_addr_o, exp_wb_addr);
              chk("wb_data", mem_data_o, exp_wb_data);
              mem[int'(mem_addr_o[31:5])] = mem_data_o;
              last_wb_addr = mem_addr_o;
              last_wb_data = mem_data_o;
            end else begin
              chk("rd_addr", mem_addr_o, exp_rd_addr);
              mem_data_i = get_line(mem_addr_o[31:5]);
              last_rd_addr = mem_addr_o;
            end
            mem_ack_i = 1;
            cnt = 0;
          end
        end
      end
    end
  end

  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input int twb, input int trd);
    int idx, w, n, exp_n;
    @(posedge clk);
    idx = int'(a[9:5]);
    w = int'(a[4:2]);
    n = 0;
    exp_n = 0;
    if (!(mv[idx] && mt[idx] == a[31:10])) begin
      exp_wb_addr = {mt[idx], a[9:5], 5'b0};
      exp_wb_data = md[idx];
      exp_rd_addr = {a[31:5], 5'b0};
      exp_n = 2 + trd + ((mv[idx] && md_dirty[idx]) ? twb : 0);
      md[idx] = get_line(a[31:5]);
      mv[idx] = 1;
      mt[idx] = a[31:10];
      md_dirty[idx] = 0;
    end
    if (wr) begin
      md[idx][w*32 +: 32] = d;
      md_dirty[idx] = 1;
    end
    exp_rdata = wr ? 32'd0 : md[idx][w*32 +: 32];
    t_wb = twb;
    t_rd = trd;
    #1;
    MemRead_i = !wr;
    MemWrite_i = wr;
    addr_i = a;
    wdata_i = d;
    while (1) begin
      @(negedge clk);
      if (!stall_o) break;
      n++;
      if (n > 400) begin
        chk("stall_timeout", 1, 0);
        break;
      end
    end
    chk("stall_cycles", n, exp_n);
    last_n = n;
    last_rdata = rdata_o;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    MemRead_i = 0;
    MemWrite_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_i = 1;
    MemRead_i = 1;
    addr_i = 32'h40;
    @(negedge clk);
    chk("rst_stall_req", stall_o, 1);
    chk("rst_enable", mem_enable_o, 0);
    chk("rst_write", mem_write_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_data", mem_data_o, 0);
    chk("rst_rdata", rdata_o, 0);
    MemRead_i = 0;
    #1 chk("rst_stall_noreq", stall_o, 0);
    @(posedge clk) #1 rst_i = 0;

    // 1: cold load miss, ack after 10 cycles
    access(0, 32'h40, 0, 0, 10);
    chk("t1_stall_n", last_n, 12);
    chk("t1_rd_addr", last_rd_addr, 32'h40);
    chk("t1_rdata", last_rdata, 32'hC0DE_0040);
    // 2: store hit then load hit
    access(1, 32'h44, 32'hDEAD_BEEF, 0, 0);
    chk("t2_store_n", last_n, 0);
    access(0, 32'h44, 0, 0, 0);
    chk("t2_rdata", last_rdata, 32'hDEAD_BEEF);
    // 3: conflict miss with dirty victim
    access(0, 32'h440, 0, 4, 5);
    chk("t3_stall_n", last_n, 11);
    chk("t3_wb_addr", last_wb_addr, 32'h40);
    chk("t3_wb_w1", last_wb_data[63:32], 32'hDEAD_BEEF);
    chk("t3_wb_w0", last_wb_data[31:0], 32'hC0DE_0040);
    chk("t3_rd_addr", last_rd_addr, 32'h440);
    chk("t3_rdata", last_rdata, 32'hC0DE_0440);
    // 4: stray ack while idle
    idle();
    auto_mem = 0;
    @(negedge clk) mem_ack_i = 1;
    @(negedge clk) mem_ack_i = 0;
    @(negedge clk);
    chk("t4_enable", mem_enable_o, 0);
    chk("t4_stall", stall_o, 0);
    auto_mem = 1;
    access(0, 32'h440, 0, 0, 0);
    chk("t4_hit_n", last_n, 0);
    // 5: reset during RD
    @(posedge clk);
    t_rd = 1000;
    #1;
    MemRead_i = 1;
    MemWrite_i = 0;
    addr_i = 32'h40;
    repeat (3) @(negedge clk);
    chk("t5_enable_pre", mem_enable_o, 1);
    chk("t5_write_pre", mem_write_o, 0);
    chk("t5_addr_pre", mem_addr_o, 32'h40);
    #2 rst_i = 1;
    #1;
    chk("t5_enable_rst", mem_enable_o, 0);
    chk("t5_addr_rst", mem_addr_o, 0);
    chk("t5_stall_rst", stall_o, 1);
    @(posedge clk) #1;
    MemRead_i = 0;
    rst_i = 0;
    for (int i = 0; i < 32; i++) begin
      mv[i] = 0;
      md_dirty[i] = 0;
    end
    access(0, 32'h40, 0, 0, 3);
    chk("t5_remiss_n", last_n, 5);
    // 6: back-to-back store hits, then evict
    access(1, 32'h48, 32'h1111_2222, 0, 0);
    access(1, 32'h4C, 32'h3333_4444, 0, 0);
    access(0, 32'h48, 0, 0, 0);
    chk("t6_rdata", last_rdata, 32'h1111_2222);
    access(0, 32'h440, 0, 2, 2);
    chk("t6_stall_n", last_n, 6);
    chk("t6_wb_w2", last_wb_data[95:64], 32'h1111_2222);
    chk("t6_wb_w3", last_wb_data[127:96], 32'h3333_4444);
    chk("t6_wb_w1", last_wb_data[63:32], 32'hDEAD_BEEF);
    idle();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
